// File: rtl/bram_stream_fifo_pkg.sv
// Shared sizing helpers for the BRAM-backed stream FIFO.
// The depth and the occupancy-counter width are both derived from the BRAM address width.
package bram_stream_fifo_pkg;

  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  function automatic int unsigned level_width(input int unsigned addr_width);
    return addr_width + 32'd1;
  endfunction

endpackage

// File: rtl/bram_simple_synch_dual_port.sv
// Simple synchronous dual-port BRAM: one write port, one registered read port.
// A read and a write to the same address on the same edge return the old contents.
module bram_simple_synch_dual_port #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr_w,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [ADDR_WIDTH-1:0] addr_r,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr_w] <= din;
    end
    dout <= mem[addr_r];
  end

endmodule

// File: rtl/bram_stream_fifo.sv
// Valid/ready stream FIFO around a simple dual-port BRAM.
// The read address looks one word ahead on a pop, so the BRAM's registered read never stalls the stream.
module bram_stream_fifo
  import bram_stream_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [ADDR_WIDTH:0]   level
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int unsigned CNT_W = level_width(ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  m_valid_q, m_valid_d;

  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic                  bram_we;

  always_comb begin
    s_ready   = (count_q != CNT_W'(DEPTH));
    push      = s_valid & s_ready;
    pop       = m_valid_q & m_ready;
    bram_we   = push & ~reset;
    addr_r    = pop ? (rd_ptr_q + ADDR_WIDTH'(1)) : rd_ptr_q;
    wr_ptr_d  = push ? (wr_ptr_q + ADDR_WIDTH'(1)) : wr_ptr_q;
    rd_ptr_d  = pop ? (rd_ptr_q + ADDR_WIDTH'(1)) : rd_ptr_q;
    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
    // A word written on this edge cannot be read back on the same edge, so it is left out here.
    m_valid_d = ((count_q - CNT_W'(pop)) != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      m_valid_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      m_valid_q <= m_valid_d;
    end
  end

  bram_simple_synch_dual_port #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bram (
    .clk    (clk),
    .we     (bram_we),
    .addr_w (wr_ptr_q),
    .din    (s_data),
    .addr_r (addr_r),
    .dout   (m_data)
  );

  assign m_valid = m_valid_q;
  assign level   = count_q;

endmodule

// File: tb/tb_bram_stream_fifo.sv
// Directed scoreboard bench for bram_stream_fifo: stimulus queues expected words, a monitor checks output order and hold stability.
module tb_bram_stream_fifo;

  localparam int AW = 3;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic [AW:0]   level;

  int errors = 0;
  int checks = 0;
  int pops   = 0;
  logic [DW-1:0] exp_q[$];

  bram_stream_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .reset   (reset),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_ready (m_ready),
    .level   (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a word until accepted; the expected output is queued at issue.
  task automatic send(input logic [DW-1:0] d);
    int waited;
    waited  = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && waited < 1000) begin
      step();
      waited++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: word %0h never accepted", d);
    end else begin
      exp_q.push_back(d);
      step();
    end
    s_valid = 1'b0;
  endtask

  // Monitor: both handshakes resolve at the following rising edge.
  logic          hold_prev = 1'b0;
  logic [DW-1:0] hold_data;
  always @(negedge clk) begin
    if (reset) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== hold_data) begin
          errors++;
          $display("FAIL hold_stable: got valid=%0b data=%0h expected valid=1 data=%0h",
                   m_valid, m_data, hold_data);
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL output_order: got unexpected word %0h, expected none", m_data);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          if (m_data !== e) begin
            errors++;
            $display("FAIL output_order: got %0h expected %0h", m_data, e);
          end
        end
        pops++;
      end
      hold_prev = m_valid & ~m_ready;
      hold_data = m_data;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    bit prod_done;
    reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    check("reset_s_ready", s_ready, 1);
    check("reset_m_valid", m_valid, 0);
    check("reset_level", level, 0);
    step();
    step();
    check("idle_m_valid", m_valid, 0);

    // Single word: visible one edge after acceptance, gone after the pop edge.
    m_ready = 1'b1;
    send(8'hA5);
    check("single_valid_after_E", m_valid, 0);
    check("single_level_after_E", level, 1);
    step();
    check("single_valid_after_E1", m_valid, 1);
    check("single_data", m_data, 8'hA5);
    step();
    check("single_valid_after_pop", m_valid, 0);
    check("single_level_after_pop", level, 0);

    // Fill to full with back-pressure, then drain.
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(DW'(i));
    check("full_s_ready", s_ready, 0);
    check("full_level", level, 8);
    s_valid = 1'b1;
    s_data  = 8'hFF;
    step();
    step();
    s_valid = 1'b0;
    check("full_extra_ignored_level", level, 8);
    check("full_head", m_data, 8'h01);
    p0 = pops;
    m_ready = 1'b1;
    step();
    check("full_pop_s_ready", s_ready, 1);
    for (int i = 0; i < 7; i++) step();
    check("drain_consecutive", pops - p0, 8);
    check("drain_level", level, 0);
    check("drain_m_valid", m_valid, 0);

    // Continuous stream: pointers wrap, level stays 1..2.
    for (int i = 0; i < 20; i++) begin
      send(8'h40 + DW'(i));
      if (level < 1 || level > 2) check("stream_level_range", level, (i == 0) ? 1 : 2);
      else checks++;
    end
    check("stream_level_end", level, 2);
    step();
    step();
    check("stream_drained_level", level, 0);
    check("stream_queue_empty", exp_q.size(), 0);

    // Random back-pressure over 200 words.
    prod_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          send(DW'(i * 7) ^ 8'h5A);
          if ($urandom_range(0, 3) == 0) step();
        end
        prod_done = 1'b1;
      end
      begin
        int n;
        n = 0;
        while (!(prod_done && level == 0) && n < 5000) begin
          m_ready = ($urandom_range(0, 1) == 1);
          step();
          n++;
        end
        m_ready = 1'b0;
      end
    join
    check("random_level_end", level, 0);
    check("random_queue_empty", exp_q.size(), 0);

    // Last word popped while a new one is pushed: one-cycle bubble.
    send(8'h11);
    step();
    check("bubble_pre_valid", m_valid, 1);
    m_ready = 1'b1;
    send(8'h33);
    check("bubble_valid_low", m_valid, 0);
    check("bubble_level", level, 1);
    step();
    check("bubble_valid_high", m_valid, 1);
    check("bubble_data", m_data, 8'h33);
    check("bubble_level_hold", level, 1);
    step();
    m_ready = 1'b0;
    check("bubble_level_end", level, 0);

    // Reset with words stored discards them.
    for (int i = 0; i < 3; i++) send(8'hC0 + DW'(i));
    check("prereset_level", level, 3);
    reset = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'hEE;
    step();
    s_valid = 1'b0;
    exp_q.delete();
    reset = 1'b0;
    check("midreset_level", level, 0);
    check("midreset_m_valid", m_valid, 0);
    check("midreset_s_ready", s_ready, 1);
    step();
    check("postreset_level", level, 0);
    check("postreset_m_valid", m_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bram_stream_fifo.md
# bram_stream_fifo

Streaming FIFO controller wrapped around the simple synchronous dual-port BRAM. Accepts a valid/ready stream on its write side, stores words in the BRAM, and presents them in order on a valid/ready read side. Absorbs the BRAM's one-cycle registered read latency so downstream stages see a plain stream. Sits between a producer stage and any consumer needing elastic buffering.

## Interface
- ADDR_WIDTH, 3, BRAM address width; depth DEPTH = 2**ADDR_WIDTH words (must be ≥ 1)
- DATA_WIDTH, 8, word width
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- s_valid  in  1  producer has a word
- s_data  in  DATA_WIDTH  producer word
- s_ready  out  1  FIFO can accept a word
- m_valid  out  1  m_data holds the head word
- m_data  out  DATA_WIDTH  head word, driven directly by BRAM dout
- m_ready  in  1  consumer takes the word
- level  out  ADDR_WIDTH+1  words stored, 0..DEPTH

## Operation
- Registered state: wr_ptr, rd_ptr (ADDR_WIDTH bits, wrap modulo DEPTH), count (ADDR_WIDTH+1 bits), m_valid.
- push = s_valid & s_ready; pop = m_valid & m_ready.
- s_ready = (count != DEPTH); combinational from count only; no push-while-full even if popping.
- BRAM write port: we = push, addr_w = wr_ptr, din = s_data; wr_ptr += 1 on push.
- BRAM read port: addr_r = pop ? rd_ptr+1 : rd_ptr (combinational); rd_ptr += 1 on pop. BRAM reads every cycle, so dout stays on the head while stalled.
- count_next = count + push − pop; level = count.
- m_valid_next = (count − pop) != 0, using count before this edge's push. Word written at edge E is not readable at edge E (BRAM returns old contents on same-address read/write), so it is excluded.
- Reset: wr_ptr = rd_ptr = 0, count = 0, m_valid = 0, s_ready = 1, level = 0. BRAM contents not cleared. m_data undefined while m_valid = 0. Reset mid-stream discards all stored words; a push or pop in the reset cycle is ignored.

## Timing
- Empty-to-output latency: word accepted at edge E → m_valid = 1 and m_data valid after edge E+1.
- Steady state: one push and one pop per cycle sustained when 0 < count < DEPTH.
- Pop at edge E with count ≥ 2 → next word on m_data after E; no bubble.
- Pop of last word with simultaneous push at edge E: count stays 1, m_valid = 0 after E, = 1 after E+1 (one-cycle bubble).
- Full: count = DEPTH → s_ready = 0; a pop at E makes s_ready = 1 after E.
- Pointer wrap DEPTH−1 → 0 invisible to the stream.
- m_valid, once high, stays high and m_data stable until pop.

## Structure
- Shared include/package: DEPTH from ADDR_WIDTH; count/level width ADDR_WIDTH+1.
- One sub-module: bram_simple_synch_dual_port, instantiated unchanged with ADDR_WIDTH/DATA_WIDTH passed through. Pointer, count and valid logic live in bram_stream_fifo.
- No other sub-modules.

## Test plan
- Reset then idle: s_ready = 1, m_valid = 0, level = 0; assert reset with 3 words stored → after reset edge level = 0, m_valid = 0.
- Single word 0xA5 pushed at edge E, m_ready = 1: m_valid rises after E+1 with m_data = 0xA5, drops after the pop edge, level returns to 0.
- Fill with 0x01..0x08 (ADDR_WIDTH = 3), m_ready = 0: s_ready = 0 after 8th push, level = 8, extra s_valid ignored. Then drain: outputs 0x01..0x08 in order on consecutive cycles.
- Continuous stream of 20 words, s_valid = m_ready = 1: pointers wrap twice, output is input delayed 2 cycles, no loss, level stays 1–2.
- Random m_ready back-pressure over 200 words: m_data stable while m_valid & !m_ready; output order equals input order.
- Count = 1, push 0x33 and pop at same edge: m_valid = 0 for one cycle, then 0x33 presented; level stays 1.
